// File: rtl/rom_read_arbiter.sv
// Two-port ROM read arbiter: round-robin grants up to two requesters per cycle
// onto ROM ports A/B and returns the read data two cycles after the handshake.
module rom_read_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 3,
    parameter int DW   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [NREQ*DW-1:0] rsp_data,
    output logic               rom_ena,
    output logic               rom_enb,
    output logic [AW-1:0]      rom_addra,
    output logic [AW-1:0]      rom_addrb,
    input  logic [DW-1:0]      rom_douta,
    input  logic [DW-1:0]      rom_doutb
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0] rr_ptr;
    logic          a_hit, b_hit;
    logic [IW-1:0] a_idx, b_idx;
    logic          a_grant, b_grant;
    logic          tag_a_v, tag_b_v;
    logic [IW-1:0] tag_a_id, tag_b_id;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return s[IW-1:0];
    endfunction

    // Port B keeps searching from just past the port-A winner, so it never re-picks A.
    always_comb begin
        a_hit = 1'b0;
        a_idx = '0;
        b_hit = 1'b0;
        b_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!a_hit && req_valid[wrap_inc(rr_ptr, k)]) begin
                a_hit = 1'b1;
                a_idx = wrap_inc(rr_ptr, k);
            end
        end
        for (int k = 1; k < NREQ; k++) begin
            if (a_hit && !b_hit && req_valid[wrap_inc(a_idx, k)]) begin
                b_hit = 1'b1;
                b_idx = wrap_inc(a_idx, k);
            end
        end
    end

    // Grants are masked while reset is held so the ROM side and handshakes go quiet at once.
    assign a_grant = a_hit & rst_n;
    assign b_grant = b_hit & rst_n;

    always_comb begin
        req_ready = '0;
        if (a_grant) req_ready[a_idx] = 1'b1;
        if (b_grant) req_ready[b_idx] = 1'b1;
    end

    assign rom_ena   = a_grant;
    assign rom_enb   = b_grant;
    assign rom_addra = a_grant ? req_addr[a_idx*AW +: AW] : '0;
    assign rom_addrb = b_grant ? req_addr[b_idx*AW +: AW] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            tag_a_v   <= 1'b0;
            tag_b_v   <= 1'b0;
            tag_a_id  <= '0;
            tag_b_id  <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            tag_a_v  <= a_grant;
            tag_b_v  <= b_grant;
            tag_a_id <= a_idx;
            tag_b_id <= b_idx;
            if (b_grant) begin
                rr_ptr <= wrap_inc(b_idx, 1);
            end else if (a_grant) begin
                rr_ptr <= wrap_inc(a_idx, 1);
            end
            rsp_valid <= '0;
            if (tag_a_v) begin
                rsp_valid[tag_a_id]          <= 1'b1;
                rsp_data[tag_a_id*DW +: DW]  <= rom_douta;
            end
            if (tag_b_v) begin
                rsp_valid[tag_b_id]          <= 1'b1;
                rsp_data[tag_b_id*DW +: DW]  <= rom_doutb;
            end
        end
    end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed and random bench for rom_read_arbiter with a 1-cycle ROM model
// (mem[k] = 8'hA0 + k) and a response scoreboard keyed by due cycle.
module tb_rom_read_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [11:0] req_addr = '0;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic        rom_ena, rom_enb;
    logic [2:0]  rom_addra, rom_addrb;
    logic [7:0]  rom_douta, rom_doutb;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int m_ptr = 0;

    typedef struct {
        int         due;
        int         id;
        logic [7:0] data;
    } exp_t;
    exp_t       q[$];
    logic [7:0] shadow[4];
    int         hit;
    logic [7:0] hit_data;

    rom_read_arbiter #(.NREQ(4), .AW(3), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rom_ena(rom_ena), .rom_enb(rom_enb),
        .rom_addra(rom_addra), .rom_addrb(rom_addrb),
        .rom_douta(rom_douta), .rom_doutb(rom_doutb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rom_ena) rom_douta <= 8'hA0 + {5'd0, rom_addra};
        if (rom_enb) rom_doutb <= 8'hA0 + {5'd0, rom_addrb};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
        end
    endtask

    // Reference arbitration: rotate the request vector so rr_ptr sits at bit 0,
    // then the lowest two set bits are the A and B winners.
    task automatic model(input logic [3:0] v, input int ptr,
                         output bit ah, output int a, output bit bh, output int b);
        logic [7:0] dbl;
        logic [7:0] rot;
        dbl = {v, v};
        rot = dbl >> ptr;
        ah = 0; bh = 0; a = 0; b = 0;
        for (int o = 0; o < 4; o++) begin
            if (rot[o]) begin
                if (!ah) begin
                    ah = 1; a = (ptr + o) % 4;
                end else if (!bh) begin
                    bh = 1; b = (ptr + o) % 4;
                end
            end
        end
    endtask

    // Called at posedge+1; drives one cycle of requests and returns at the next posedge+1.
    task automatic step(input logic [3:0] v, input logic [11:0] a);
        bit         ah, bh;
        int         ma, mb;
        logic [3:0] exp_rdy;
        logic [2:0] aa, ab;
        req_valid = v;
        req_addr  = a;
        #3;
        model(v, m_ptr, ah, ma, bh, mb);
        exp_rdy = '0;
        if (ah) exp_rdy[ma] = 1'b1;
        if (bh) exp_rdy[mb] = 1'b1;
        aa = ah ? a[ma*3 +: 3] : 3'd0;
        ab = bh ? a[mb*3 +: 3] : 3'd0;
        chk("req_ready", req_ready, exp_rdy);
        chk("rom_ena", rom_ena, ah);
        chk("rom_addra", rom_addra, aa);
        chk("rom_enb", rom_enb, bh);
        chk("rom_addrb", rom_addrb, ab);
        if (ah) q.push_back('{cyc + 2, ma, 8'hA0 + {5'd0, aa}});
        if (bh) q.push_back('{cyc + 2, mb, 8'hA0 + {5'd0, ab}});
        if (bh) m_ptr = (mb + 1) % 4;
        else if (ah) m_ptr = (ma + 1) % 4;
        @(posedge clk);
        #1;
        chk("rr_ptr", dut.rr_ptr, m_ptr);
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_ready", req_ready, 4'b0000);
        chk("rst_rom_ena", rom_ena, 1'b0);
        chk("rst_rom_enb", rom_enb, 1'b0);
        chk("rst_rom_addra", rom_addra, 3'd0);
        chk("rst_rom_addrb", rom_addrb, 3'd0);
        chk("rst_rsp_valid", rsp_valid, 4'b0000);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rr_ptr", dut.rr_ptr, 2'd0);
    endtask

    // Assert reset with every requester active; outputs must drop without a clock edge.
    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_addr  = 12'hfff;
        #1;
        check_reset_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n     = 1'b1;
        req_valid = '0;
        m_ptr     = 0;
    endtask

    task automatic drain();
        for (int k = 0; k < 3; k++) step(4'b0000, 12'h000);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            for (int i = 0; i < 4; i++) shadow[i] = 8'h00;
            chk("rsp_valid_in_reset", rsp_valid, 4'b0000);
            chk("rsp_data_in_reset", rsp_data, 32'd0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                hit = 0;
                hit_data = 8'h00;
                foreach (q[j]) begin
                    if (q[j].due == cyc && q[j].id == i) begin
                        hit = 1;
                        hit_data = q[j].data;
                    end
                end
                chk($sformatf("rsp_valid[%0d]", i), rsp_valid[i], hit);
                if (hit != 0) shadow[i] = hit_data;
                chk($sformatf("rsp_data[%0d]", i), rsp_data[i*8 +: 8], shadow[i]);
            end
            while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
        end
    end

    initial begin
        #1;
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_addr  = 12'hfff;
        #2;
        check_reset_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        req_valid = '0;
        m_ptr     = 0;

        step(4'b0000, 12'h000);
        step(4'b0000, 12'h000);

        step(4'b0001, {3'd0, 3'd0, 3'd0, 3'd3});
        drain();

        do_reset();
        step(4'b0110, {3'd0, 3'd7, 3'd5, 3'd0});
        drain();

        do_reset();
        for (int k = 0; k < 4; k++)
            step(4'b1111, {3'(k + 3), 3'(k + 2), 3'(k + 1), 3'(k)});
        drain();

        step(4'b1001, {3'd2, 3'd0, 3'd0, 3'd2});
        drain();

        step(4'b0001, {3'd0, 3'd0, 3'd0, 3'd1});
        step(4'b0001, {3'd0, 3'd0, 3'd0, 3'd6});
        drain();

        for (int k = 0; k < 40; k++)
            step(4'($urandom_range(0, 15)), 12'($urandom));
        drain();

        step(4'b0011, {3'd0, 3'd0, 3'd4, 3'd1});
        do_reset();
        step(4'b0000, 12'h000);
        step(4'b0000, 12'h000);
        req_valid = 4'b0100;
        req_addr  = {3'd0, 3'd4, 3'd0, 3'd0};
        #3;
        chk("post_reset_ready", req_ready, 4'b0100);
        chk("post_reset_ena", rom_ena, 1'b1);
        chk("post_reset_addra", rom_addra, 3'd4);
        @(posedge clk);
        #1;
        req_valid = '0;
        m_ptr     = 3;
        q.push_back('{cyc + 1, 2, 8'hA4});
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
